nn_sample_sequencer: RTL

Top-level training/inference scheduler that sits in front of the layer control unit (CU).
- Accepts sample data (inputs, plus targets when training) from a host stream via valid/ready and writes it into the input and target buffers.
- Kicks the CU for one forward pass, or one forward+backprop pass, and waits for its completion pulse.
- Counts samples and epochs, and aborts a hung CU with a watchdog.

---
 rtl/nn_pkg.sv | 19 +
 rtl/nn_watchdog.sv | 29 ++
 rtl/nn_sample_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the NN sequencing blocks.
// Library-wide sizing and the sample sequencer state encoding.
package nn_pkg;

   localparam int MAX_NEURONS           = 8;
   localparam int DATA_W                = 16;
   localparam int LEARNING_RATE_DIVIDER = 4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_IN  = 3'd1,
      S_LOAD_TGT = 3'd2,
      S_KICK     = 3'd3,
      S_WAIT     = 3'd4,
      S_NEXT     = 3'd5,
      S_ABORT    = 3'd6
   } seq_state_t;

endpackage

// File: rtl/nn_watchdog.sv
// Saturating cycle counter with clear and enable.
// Pulses expire while enabled on the terminal count TIMEOUT_CYCLES-1.
module nn_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // Holds at LAST so a late cu_valid can never see a wrapped count.
   always_ff @(posedge CLK) begin
      if (!RST_N || clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expire = en && (cnt == LAST);

endmodule

// File: rtl/nn_sample_sequencer.sv
// Training/inference scheduler in front of the layer control unit: loads each
// sample into the input/target buffers, kicks the CU and counts samples/epochs.
module nn_sample_sequencer #(
   parameter  int DATA_W         = nn_pkg::DATA_W,
   parameter  int MAX_NEURONS    = nn_pkg::MAX_NEURONS,
   parameter  int NUM_SAMPLES    = 16,
   parameter  int NUM_EPOCHS     = 100,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int AW = $clog2(MAX_NEURONS),
   localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
   localparam int EW = (NUM_EPOCHS > 1) ? $clog2(NUM_EPOCHS) : 1
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               start,
   input  logic               abort,
   input  logic               train_mode,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_data,
   output logic               in_we,
   output logic [AW-1:0]      in_addr,
   output logic               tgt_we,
   output logic [AW-1:0]      tgt_addr,
   output logic [DATA_W-1:0]  buf_wdata,
   output logic               cu_done,
   output logic               cu_train,
   output logic               cu_rst,
   input  logic               cu_valid,
   output logic [SW-1:0]      sample_idx,
   output logic [EW-1:0]      epoch_idx,
   output logic               busy,
   output logic               finished,
   output logic               timeout_err,
   output nn_pkg::seq_state_t state_dbg
);

   localparam logic [AW-1:0] ELEM_LAST   = AW'(MAX_NEURONS - 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(NUM_SAMPLES - 1);
   localparam logic [EW-1:0] EPOCH_LAST  = EW'(NUM_EPOCHS - 1);

   nn_pkg::seq_state_t state, state_nxt;

   logic          train_q;
   logic [AW-1:0] elem_cnt;
   logic          elem_last, sample_last, epoch_last;
   logic          beat;
   logic          start_acc, next_adv, timeout_hit;
   logic          wd_clr, wd_en, wd_expire;

   assign elem_last   = (elem_cnt == ELEM_LAST);
   assign sample_last = (sample_idx == SAMPLE_LAST);
   assign epoch_last  = (epoch_idx == EPOCH_LAST);

   // Host stream: an element transfers on a rising edge where s_valid && s_ready.
   // s_ready depends only on state and abort, never on s_valid; the sender holds
   // s_data stable while s_valid is high and s_ready is low.
   assign beat = s_valid && s_ready;

   always_comb begin
      state_nxt   = state;
      s_ready     = 1'b0;
      in_we       = 1'b0;
      tgt_we      = 1'b0;
      finished    = 1'b0;
      wd_clr      = 1'b0;
      wd_en       = 1'b0;
      timeout_hit = 1'b0;
      next_adv    = 1'b0;
      start_acc   = 1'b0;
      if ((state != nn_pkg::S_IDLE) && abort) begin
         state_nxt = nn_pkg::S_ABORT;
      end else begin
         case (state)
            nn_pkg::S_IDLE: begin
               if (start) begin
                  start_acc = 1'b1;
                  state_nxt = nn_pkg::S_LOAD_IN;
               end
            end
            nn_pkg::S_LOAD_IN: begin
               s_ready = 1'b1;
               in_we   = s_valid;
               if (s_valid && elem_last) begin
                  state_nxt = train_q ? nn_pkg::S_LOAD_TGT : nn_pkg::S_KICK;
               end
            end
            nn_pkg::S_LOAD_TGT: begin
               s_ready = 1'b1;
               tgt_we  = s_valid;
               if (s_valid && elem_last) begin
                  state_nxt = nn_pkg::S_KICK;
               end
            end
            nn_pkg::S_KICK: begin
               wd_clr    = 1'b1;
               state_nxt = nn_pkg::S_WAIT;
            end
            nn_pkg::S_WAIT: begin
               wd_en = 1'b1;
               if (cu_valid) begin
                  state_nxt = nn_pkg::S_NEXT;
               end else if (wd_expire) begin
                  timeout_hit = 1'b1;
                  state_nxt   = nn_pkg::S_ABORT;
               end
            end
            nn_pkg::S_NEXT: begin
               next_adv = 1'b1;
               if (sample_last && (!train_q || epoch_last)) begin
                  finished  = 1'b1;
                  state_nxt = nn_pkg::S_IDLE;
               end else begin
                  state_nxt = nn_pkg::S_LOAD_IN;
               end
            end
            nn_pkg::S_ABORT: begin
               state_nxt = nn_pkg::S_IDLE;
            end
            default: begin
               state_nxt = nn_pkg::S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= nn_pkg::S_IDLE;
         train_q     <= 1'b0;
         elem_cnt    <= '0;
         sample_idx  <= '0;
         epoch_idx   <= '0;
         timeout_err <= 1'b0;
         cu_rst      <= 1'b1;
      end else begin
         state  <= state_nxt;
         // Registered so the CU reset is a clean full-cycle pulse during ABORT.
         cu_rst <= (state_nxt == nn_pkg::S_ABORT);
         if (start_acc) begin
            train_q     <= train_mode;
            elem_cnt    <= '0;
            sample_idx  <= '0;
            epoch_idx   <= '0;
            timeout_err <= 1'b0;
         end
         if (beat) begin
            elem_cnt <= elem_last ? '0 : elem_cnt + AW'(1);
         end
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
         if (next_adv) begin
            if (sample_last) begin
               sample_idx <= '0;
               if (train_q && !epoch_last) begin
                  epoch_idx <= epoch_idx + EW'(1);
               end
            end else begin
               sample_idx <= sample_idx + SW'(1);
            end
         end
      end
   end

   nn_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   assign in_addr   = elem_cnt;
   assign tgt_addr  = elem_cnt;
   assign buf_wdata = s_data;
   assign busy      = (state != nn_pkg::S_IDLE);
   // Low only in KICK; high everywhere else parks the CU in INIT.
   assign cu_done   = (state != nn_pkg::S_KICK);
   assign cu_train  = busy && train_q;
   assign state_dbg = state;

endmodule
